// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter.
//   uart_state_e    : receiver FSM state encoding (3 bits)
//   uart_bit_cycles : clocks per serial bit for a given clock/baud pair
//   uart_parity     : parity bit value; sel=1 -> XOR of data, sel=0 -> XNOR
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  localparam int unsigned UART_DATA_BITS = 8;

  function automatic int unsigned uart_bit_cycles(input int unsigned clk_hz,
                                                  input int unsigned baud);
    return (clk_hz / baud) + 1;
  endfunction

  function automatic logic uart_parity(input logic [7:0] data, input logic sel);
    return sel ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
//   clk_i   : clock
//   rst_n_i : asynchronous active-low reset (flops reset to 1 = idle line)
//   d_i     : asynchronous input
//   q_o     : synchronized output, 2-cycle latency
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= '1;
    else          sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional parity, 1 or 2 stop bits.
//   clk_i, rst_n_i       : clock, asynchronous active-low reset
//   rx_i                 : serial line (asynchronous, idles high)
//   parity_en_i          : expect a parity bit after the data bits
//   parity_sel_i         : parity = sel ? ^data : ~^data
//   stop_sel_i           : 0 = one stop bit, 1 = two stop bits
//   data_o               : last received byte
//   data_valid_o         : one-cycle pulse when data_o / error flags update
//   parity_err_o         : parity mismatch on the last frame
//   frame_err_o          : a stop bit was sampled low on the last frame
//   busy_o               : frame reception in progress
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling
// around each bit centre (decision one cycle later).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned p_clk_speed_hz = 50_000_000,
  parameter int unsigned p_baud_rate    = 9_600
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rx_i,
  input  logic       parity_en_i,
  input  logic       parity_sel_i,
  input  logic       stop_sel_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned BIT_CYC  = uart_bit_cycles(p_clk_speed_hz, p_baud_rate);
  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam int unsigned CW       = $clog2(BIT_CYC) + 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned MAJ_OFS  = 1;
`else
  localparam int unsigned MAJ_OFS  = 0;
`endif
  // Only the start decision carries the majority offset; the counter is
  // cleared there, so every later BIT_CYC-1 decision lands at centre+1 too.
  localparam logic [CW-1:0] START_DEC = CW'(HALF_CYC + MAJ_OFS);
  localparam logic [CW-1:0] BIT_DEC   = CW'(BIT_CYC - 1);

  uart_state_e state_q, state_d;
  logic        rxs, rx_bit;
  logic [CW-1:0] cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        par_en_q, par_sel_q, two_stop_q, stop_cnt_q;
  logic        perr_q, ferr_q;
  logic        start_dec, bit_dec, last_stop;

  uart_rx_sync u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (rx_i),
    .q_o     (rxs)
  );

`ifdef UART_RX_MAJORITY_EN
  // rx_hist[0] = sample at centre, rx_hist[1] = centre-1, rxs = centre+1
  logic [1:0] rx_hist;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rx_hist <= '1;
    else          rx_hist <= {rx_hist[0], rxs};
  end
  assign rx_bit = (rxs & rx_hist[0]) | (rxs & rx_hist[1]) | (rx_hist[0] & rx_hist[1]);
`else
  assign rx_bit = rxs;
`endif

  assign start_dec = (cnt_q == START_DEC);
  assign bit_dec   = (cnt_q == BIT_DEC);
  assign last_stop = !two_stop_q || stop_cnt_q;
  assign busy_o    = (state_q != ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (!rxs) state_d = ST_START;
      ST_START:  if (start_dec) state_d = rx_bit ? ST_IDLE : ST_DATA;
      ST_DATA:   if (bit_dec && bit_cnt_q == 3'(UART_DATA_BITS - 1))
                   state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_dec) state_d = ST_STOP;
      ST_STOP:   if (bit_dec && last_stop) state_d = rx_bit ? ST_IDLE : ST_BREAK;
      ST_BREAK:  if (rxs) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_sel_q    <= 1'b0;
      two_stop_q   <= 1'b0;
      stop_cnt_q   <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      cnt_q        <= cnt_q + CW'(1);
      data_valid_o <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          cnt_q      <= '0;
          bit_cnt_q  <= '0;
          stop_cnt_q <= 1'b0;
          perr_q     <= 1'b0;
          ferr_q     <= 1'b0;
          par_en_q   <= parity_en_i;
          par_sel_q  <= parity_sel_i;
          two_stop_q <= stop_sel_i;
        end
        ST_START: if (start_dec) cnt_q <= '0;
        ST_DATA: if (bit_dec) begin
          shift_q[bit_cnt_q] <= rx_bit;
          bit_cnt_q          <= bit_cnt_q + 3'd1;
          cnt_q              <= '0;
        end
        ST_PARITY: if (bit_dec) begin
          perr_q <= (rx_bit != uart_parity(shift_q, par_sel_q));
          cnt_q  <= '0;
        end
        ST_STOP: if (bit_dec) begin
          ferr_q     <= ferr_q | ~rx_bit;
          stop_cnt_q <= 1'b1;
          cnt_q      <= '0;
          if (last_stop) begin
            data_o       <= shift_q;
            parity_err_o <= perr_q;
            frame_err_o  <= ferr_q | ~rx_bit;
            data_valid_o <= 1'b1;
          end
        end
        ST_BREAK: cnt_q <= '0;
        default:  cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int BIT  = 11;   // 1 MHz / 100 kBd + 1
  localparam int HALF = 5;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       rx_i = 1'b1;
  logic       parity_en_i = 1'b0, parity_sel_i = 1'b0, stop_sel_i = 1'b0;
  logic [7:0] data_o;
  logic       data_valid_o, parity_err_o, frame_err_o, busy_o;

  uart_rx #(.p_clk_speed_hz(1_000_000), .p_baud_rate(100_000)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .rx_i         (rx_i),
    .parity_en_i  (parity_en_i),
    .parity_sel_i (parity_sel_i),
    .stop_sel_i   (stop_sel_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected frame outcome: cycle of the valid pulse and the reported values.
  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       busy;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic model_par(input logic [7:0] d, input logic sel);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return sel ? (ones % 2 == 1) : (ones % 2 == 0);
  endfunction

  // Per-cycle comparison against the model's expected outputs.
  logic [7:0] hold_d = '0;
  logic       hold_p = 1'b0, hold_f = 1'b0;
  always @(negedge clk) begin
    logic exp_v;
    if (!rst_n_i) begin
      hold_d = '0; hold_p = 1'b0; hold_f = 1'b0;
      chk("rst_valid", data_valid_o, 0);
      chk("rst_busy", busy_o, 0);
    end else begin
      exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("valid", data_valid_o, exp_v);
      if (exp_v) begin
        hold_d = exp_q[0].data;
        hold_p = exp_q[0].perr;
        hold_f = exp_q[0].ferr;
        chk("busy_at_valid", busy_o, exp_q[0].busy);
        void'(exp_q.pop_front());
      end
    end
    chk("data", data_o, hold_d);
    chk("perr", parity_err_o, hold_p);
    chk("ferr", frame_err_o, hold_f);
  end

  int busy_cnt = 0;
  always @(negedge clk) if (busy_o) busy_cnt++;

  // Called at #1 after a posedge; holds the line for one bit time.
  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  // Sends one frame and queues its expected result. The line is left at the
  // level of the last stop bit. Config inputs are inverted mid-frame.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic psel,
                            input logic pbit, input logic two, input logic stop0);
    exp_t e;
    int   n;
    parity_en_i  = pen;
    parity_sel_i = psel;
    stop_sel_i   = two;
    n      = 8 + int'(pen) + 1 + int'(two);
    e.cyc  = cyc + 9 + BIT * n + MAJ;
    e.data = d;
    e.perr = pen && (pbit != model_par(d, psel));
    e.ferr = !stop0;
    e.busy = two ? 1'b0 : !stop0;
    exp_q.push_back(e);
    drive_bit(1'b0);
    parity_en_i  = ~pen;
    parity_sel_i = ~psel;
    stop_sel_i   = ~two;
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(stop0);
    if (two) drive_bit(1'b1);
    parity_en_i  = pen;
    parity_sel_i = psel;
    stop_sel_i   = two;
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", data_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_valid", data_valid_o, 0);
    rst_n_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // model pins: 0x3C has four ones, even-parity-style bit is 1
    chk("model_par_3c", model_par(8'h3C, 1'b0), 1);
    chk("model_par_a5", model_par(8'hA5, 1'b1), 0);

    // 0xA5, 8N1
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("a5_data", data_o, 8'hA5);
    chk("a5_errs", {parity_err_o, frame_err_o}, 0);
    chk("a5_busy", busy_o, 0);
    repeat (3) @(posedge clk);
    #1;

    // 0x3C with correct then wrong parity
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("3c_good_perr", parity_err_o, 0);
    repeat (2) @(posedge clk);
    #1;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("3c_bad_perr", parity_err_o, 1);
    chk("3c_bad_data", data_o, 8'h3C);
    repeat (2) @(posedge clk);
    #1;

    // 0x55 with low stop bit, line held low: one pulse, then BREAK
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("brk_ferr", frame_err_o, 1);
    chk("brk_data", data_o, 8'h55);
    repeat (40) @(posedge clk);
    #1;
    chk("brk_busy_held", busy_o, 1);
    rx_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("brk_idle", busy_o, 0);

    // 3-cycle glitch on idle line
    busy_cnt = 0;
    rx_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_i = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk("glitch_busy_cycles", busy_cnt, 6 + MAJ);
    chk("glitch_busy_bound", busy_cnt <= HALF + 3, 1);
    chk("glitch_busy_end", busy_o, 0);

    // two stop bits, back-to-back frames
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("b2b_first", data_o, 8'h00);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("b2b_second", data_o, 8'hFF);
    chk("b2b_errs", {parity_err_o, frame_err_o}, 0);
    repeat (3) @(posedge clk);
    #1;

    // reset during data bit 4, then a clean frame
    stop_sel_i = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rx_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy_o, 1);
    rst_n_i = 1'b0;
    #1;
    chk("midrst_data", data_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_flags", {data_valid_o, parity_err_o, frame_err_o}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("post_rst_data", data_o, 8'h81);
    repeat (5) @(posedge clk);
    #1;

    chk("all_frames_seen", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver: the downstream counterpart of the team's transmitter; consumes the serial line and produces parallel bytes.
- Recovers 8-bit LSB-first frames with optional parity and 1 or 2 stop bits.
- Reports each frame with a one-cycle valid pulse plus parity and framing error flags.
- Sits between the pad/line and the byte consumer (FIFO or register block); has no backpressure.

Parameters:
- p_clk_speed_hz, 50_000_000, clock frequency in Hz.
- p_baud_rate, 9_600, line baud rate.
- Derived localparams:
  - U_CYCLES_PER_BIT = p_clk_speed_hz / p_baud_rate.
  - BIT_CYC = U_CYCLES_PER_BIT + 1: clocks per bit.
  - HALF_CYC = BIT_CYC / 2.
  - Counter width = $clog2(BIT_CYC) + 1.

Ports:
- clk_i  in  1  single clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- rx_i  in  1  serial line, asynchronous to clk_i, idles high.
- parity_en_i  in  1  expect a parity bit after the data bits.
- parity_sel_i  in  1  parity bit = parity_sel_i ? ^data : ~^data.
- stop_sel_i  in  1  0 = one stop bit, 1 = two stop bits.
- data_o  out  8  last received byte.
- data_valid_o  out  1  one-cycle pulse: data_o and the error flags are updated.
- parity_err_o  out  1  parity mismatch on the last frame.
- frame_err_o  out  1  a stop bit was sampled low on the last frame.
- busy_o  out  1  frame reception in progress (state != IDLE).

Behaviour:
- Reset (async assert, sync deassert internally not required): state IDLE, synchronizer flops = 1, data_o = 0, data_valid_o = 0, parity_err_o = 0, frame_err_o = 0, busy_o = 0, counters = 0.
- Input synchronization:
  - rx_i passes through 2 flops; all logic uses the synchronized bit rxs.
  - Synchronizer latency is 2 cycles.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - On rxs == 0: go to START, clear the cycle counter.
  - Latch parity_en_i, parity_sel_i and stop_sel_i; changes to these inputs mid-frame are ignored.
- START:
  - At count == HALF_CYC, sample rxs.
  - If 1: false start; return to IDLE with no output activity.
  - If 0: clear the counter and go to DATA. All later samples fall at bit centre.
- DATA:
  - At count == BIT_CYC-1, sample and shift into bit[bit_cnt], LSB first, then clear the counter.
  - After bit 7: go to PARITY if parity was enabled, else STOP.
- PARITY:
  - At count == BIT_CYC-1, sample.
  - perr = sample != expected bit computed from the shifted byte.
- STOP:
  - At each count == BIT_CYC-1, sample; any 0 sets ferr.
  - Sample 1 stop bit, or 2 if stop_sel latched 1.
  - After the last stop sample, on the next cycle:
    - data_o <= byte, parity_err_o <= perr (0 when parity is disabled), frame_err_o <= ferr.
    - data_valid_o = 1 for exactly 1 cycle.
  - Next state is IDLE if the last sample was 1, else BREAK.
- BREAK: wait until rxs == 1, then go to IDLE. A held-low line never produces repeated frames.
- Output holding: data_o and the error flags hold their values until the next data_valid_o. No overrun detection; the consumer must take the byte within one frame time.
- Re-arm: returning to IDLE at the centre of the stop bit allows back-to-back frames with zero idle gap.
- Reset mid-frame: immediate abort. Outputs return to reset values; the next falling edge after reset starts a fresh frame.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each START, DATA, PARITY and STOP decision uses a 2-of-3 majority of rxs at counts centre-1, centre and centre+1.
  - The decision is taken at centre+1; the counter is not re-phased.
  - data_valid_o moves one cycle later.
- Undefined: single sample at the centre count; no extra logic.

Decomposition:
- Package uart_pkg:
  - State encoding localparams (shared width, 3 bits).
  - Cycles-per-bit calculation.
  - Parity-function definition (parity_sel semantics), shared with the transmitter.
- Sub-module uart_rx_sync: 2-flop synchronizer, reset value 1.

Test Plan:
- Common setup: p_clk_speed_hz = 1_000_000, p_baud_rate = 100_000 (BIT_CYC = 11), line driven by a bench model or the team's transmitter.
- 0xA5, no parity, 1 stop -> single data_valid_o pulse; data_o = 0xA5, parity_err_o = 0, frame_err_o = 0; busy_o low within 1 cycle after the pulse.
- 0x3C, parity_en = 1, parity_sel = 0, correct parity bit (1) -> parity_err_o = 0. Same byte with parity bit 0 -> parity_err_o = 1, data_o = 0x3C.
- 0x55 with the stop bit driven 0, then line held low 40 cycles, then high -> one valid pulse with frame_err_o = 1; no further valid; state passes BREAK -> IDLE.
- 3-cycle low glitch on an idle line -> no data_valid_o; busy_o high for ≤ HALF_CYC + 3 cycles, then 0.
- stop_sel = 1, frames 0x00 then 0xFF back-to-back -> two valid pulses, data_o = 0x00 then 0xFF, no errors.
- rst_n_i asserted during data bit 4 -> outputs at reset values in the same cycle; following frame 0x81 received correctly.
